// File: rtl/mul_reservation_station.sv
// Reservation station in front of the multiplier: holds dispatched multiply ops,
// wakes operands from the CDB and issues one ready op to an idle multiplier.
module mul_reservation_station #(
  parameter int         DEPTH    = 3,
  parameter logic [2:0] TAG_BASE = 3'b101,
  parameter logic [2:0] NULL_TAG = 3'b000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Disp_Valid,
  input  logic [2:0] Disp_Op1_Tag,
  input  logic [7:0] Disp_Op1_Val,
  input  logic [2:0] Disp_Op2_Tag,
  input  logic [7:0] Disp_Op2_Val,
  output logic       RS_Full,
  output logic [2:0] Disp_Tag,
  input  logic       CDB_Valid,
  input  logic [2:0] CDB_Tag,
  input  logic [7:0] CDB_Data,
  input  logic       MUL_Status,
  output logic [2:0] MUL_Tag_ip,
  output logic [7:0] Source_Reg1,
  output logic [7:0] Source_Reg2,
  output logic [2:0] Occupancy
);

  logic [DEPTH-1:0] busy_r;
  logic [2:0]       q1_r [DEPTH];
  logic [7:0]       v1_r [DEPTH];
  logic [2:0]       q2_r [DEPTH];
  logic [7:0]       v2_r [DEPTH];
  logic             issued_r;
  logic [2:0]       tag_ip_r;
  logic [7:0]       src1_r;
  logic [7:0]       src2_r;
  logic [2:0]       occ_r;

  logic             alloc_found_s;
  logic [1:0]       alloc_idx_s;
  logic             dispatch_en_s;
  logic             issue_found_s;
  logic [1:0]       issue_idx_s;
  logic [7:0]       issue_v1_s;
  logic [7:0]       issue_v2_s;
  logic             issue_en_s;
  logic [DEPTH-1:0] busy_nxt_s;
  logic [2:0]       occ_nxt_s;

  // A pending operand takes the broadcast value when its producer tag is on the CDB;
  // a ready operand (or a NULL_TAG broadcast) is never overwritten.
  function automatic logic [10:0] resolve_op(input logic [2:0] tag, input logic [7:0] val,
                                             input logic cdb_v, input logic [2:0] cdb_t,
                                             input logic [7:0] cdb_d);
    logic [10:0] res;
    if (tag == NULL_TAG) begin
      res = {NULL_TAG, val};
    end else if (cdb_v && (tag == cdb_t)) begin
      res = {NULL_TAG, cdb_d};
    end else begin
      res = {tag, val};
    end
    return res;
  endfunction

  // Lowest-index free entry for the next dispatch.
  always_comb begin
    alloc_found_s = 1'b0;
    alloc_idx_s   = 2'd0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy_r[i]) begin
        alloc_found_s = 1'b1;
        alloc_idx_s   = 2'(i);
      end else begin
        alloc_found_s = alloc_found_s;
      end
    end
  end

  assign RS_Full       = ~alloc_found_s;
  assign Disp_Tag      = TAG_BASE + {1'b0, alloc_idx_s};
  assign dispatch_en_s = Disp_Valid & alloc_found_s;

  // Lowest-index entry with both operands ready, taken from registered state only.
  always_comb begin
    issue_found_s = 1'b0;
    issue_idx_s   = 2'd0;
    issue_v1_s    = 8'd0;
    issue_v2_s    = 8'd0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (busy_r[i] && (q1_r[i] == NULL_TAG) && (q2_r[i] == NULL_TAG)) begin
        issue_found_s = 1'b1;
        issue_idx_s   = 2'(i);
        issue_v1_s    = v1_r[i];
        issue_v2_s    = v2_r[i];
      end else begin
        issue_found_s = issue_found_s;
      end
    end
  end

  // issued_r blocks the cycle after an issue, before the multiplier raises MUL_Status.
  assign issue_en_s = issue_found_s & ~MUL_Status & ~issued_r;

  // Next busy vector and its population count; issue and dispatch never hit the same entry.
  always_comb begin
    busy_nxt_s = busy_r;
    occ_nxt_s  = 3'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if (issue_en_s && (issue_idx_s == 2'(i))) begin
        busy_nxt_s[i] = 1'b0;
      end else if (dispatch_en_s && (alloc_idx_s == 2'(i))) begin
        busy_nxt_s[i] = 1'b1;
      end else begin
        busy_nxt_s[i] = busy_r[i];
      end
      occ_nxt_s = occ_nxt_s + {2'b00, busy_nxt_s[i]};
    end
  end

  // Entry storage: dispatch capture with same-cycle forwarding, and CDB snoop of busy entries.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q1_r[i] <= NULL_TAG;
        v1_r[i] <= 8'd0;
        q2_r[i] <= NULL_TAG;
        v2_r[i] <= 8'd0;
      end
    end else begin
      busy_r <= busy_nxt_s;
      for (int i = 0; i < DEPTH; i++) begin
        if (dispatch_en_s && (alloc_idx_s == 2'(i))) begin
          {q1_r[i], v1_r[i]} <= resolve_op(Disp_Op1_Tag, Disp_Op1_Val, CDB_Valid, CDB_Tag, CDB_Data);
          {q2_r[i], v2_r[i]} <= resolve_op(Disp_Op2_Tag, Disp_Op2_Val, CDB_Valid, CDB_Tag, CDB_Data);
        end else if (busy_r[i]) begin
          {q1_r[i], v1_r[i]} <= resolve_op(q1_r[i], v1_r[i], CDB_Valid, CDB_Tag, CDB_Data);
          {q2_r[i], v2_r[i]} <= resolve_op(q2_r[i], v2_r[i], CDB_Valid, CDB_Tag, CDB_Data);
        end else begin
          q1_r[i] <= q1_r[i];
        end
      end
    end
  end

  // Issue port: one-cycle pulse of tag and operands, idle value otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      issued_r <= 1'b0;
      tag_ip_r <= NULL_TAG;
      src1_r   <= 8'd0;
      src2_r   <= 8'd0;
      occ_r    <= 3'd0;
    end else begin
      issued_r <= issue_en_s;
      occ_r    <= occ_nxt_s;
      if (issue_en_s) begin
        tag_ip_r <= TAG_BASE + {1'b0, issue_idx_s};
        src1_r   <= issue_v1_s;
        src2_r   <= issue_v2_s;
      end else begin
        tag_ip_r <= NULL_TAG;
        src1_r   <= 8'd0;
        src2_r   <= 8'd0;
      end
    end
  end

  assign MUL_Tag_ip  = tag_ip_r;
  assign Source_Reg1 = src1_r;
  assign Source_Reg2 = src2_r;
  assign Occupancy   = occ_r;

endmodule

// File: tb/tb_mul_reservation_station.sv
// Directed bench for mul_reservation_station: expected issues are queued at dispatch
// and matched by a monitor whenever MUL_Tag_ip is non-null.
module tb_mul_reservation_station;

  logic       clk = 1'b0;
  logic       reset;
  logic       Disp_Valid;
  logic [2:0] Disp_Op1_Tag;
  logic [7:0] Disp_Op1_Val;
  logic [2:0] Disp_Op2_Tag;
  logic [7:0] Disp_Op2_Val;
  logic       RS_Full;
  logic [2:0] Disp_Tag;
  logic       CDB_Valid;
  logic [2:0] CDB_Tag;
  logic [7:0] CDB_Data;
  logic       MUL_Status;
  logic [2:0] MUL_Tag_ip;
  logic [7:0] Source_Reg1;
  logic [7:0] Source_Reg2;
  logic [2:0] Occupancy;

  typedef struct packed {
    logic [2:0] tag;
    logic [7:0] s1;
    logic [7:0] s2;
  } exp_t;

  exp_t sb_q[$];
  exp_t exp_e;
  logic prev_issue = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  mul_reservation_station dut (
    .clk         (clk),
    .reset       (reset),
    .Disp_Valid  (Disp_Valid),
    .Disp_Op1_Tag(Disp_Op1_Tag),
    .Disp_Op1_Val(Disp_Op1_Val),
    .Disp_Op2_Tag(Disp_Op2_Tag),
    .Disp_Op2_Val(Disp_Op2_Val),
    .RS_Full     (RS_Full),
    .Disp_Tag    (Disp_Tag),
    .CDB_Valid   (CDB_Valid),
    .CDB_Tag     (CDB_Tag),
    .CDB_Data    (CDB_Data),
    .MUL_Status  (MUL_Status),
    .MUL_Tag_ip  (MUL_Tag_ip),
    .Source_Reg1 (Source_Reg1),
    .Source_Reg2 (Source_Reg2),
    .Occupancy   (Occupancy)
  );

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive_disp(input logic [2:0] t1, input logic [7:0] v1,
                            input logic [2:0] t2, input logic [7:0] v2);
    Disp_Valid   = 1'b1;
    Disp_Op1_Tag = t1;
    Disp_Op1_Val = v1;
    Disp_Op2_Tag = t2;
    Disp_Op2_Val = v2;
  endtask

  task automatic clear_disp();
    Disp_Valid   = 1'b0;
    Disp_Op1_Tag = 3'd0;
    Disp_Op1_Val = 8'd0;
    Disp_Op2_Tag = 3'd0;
    Disp_Op2_Val = 8'd0;
  endtask

  task automatic push_exp(input logic [2:0] t, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    e.tag = t;
    e.s1  = a;
    e.s2  = b;
    sb_q.push_back(e);
  endtask

  // Issue monitor: every non-null issue must match the head of the scoreboard.
  always @(negedge clk) begin
    if (reset) begin
      prev_issue = 1'b0;
    end else if (MUL_Tag_ip != 3'b000) begin
      check_val("b2b_issue", 32'(prev_issue), 32'd0);
      if (sb_q.size() == 0) begin
        check_val("unexpected_issue", 32'(MUL_Tag_ip), 32'd0);
      end else begin
        exp_e = sb_q.pop_front();
        check_val("sb_tag", 32'(MUL_Tag_ip), 32'(exp_e.tag));
        check_val("sb_src1", 32'(Source_Reg1), 32'(exp_e.s1));
        check_val("sb_src2", 32'(Source_Reg2), 32'(exp_e.s2));
      end
      prev_issue = 1'b1;
    end else begin
      check_val("idle_src", 32'({Source_Reg1, Source_Reg2}), 32'd0);
      prev_issue = 1'b0;
    end
  end

  initial begin
    reset      = 1'b1;
    CDB_Valid  = 1'b0;
    CDB_Tag    = 3'd0;
    CDB_Data   = 8'd0;
    MUL_Status = 1'b0;
    clear_disp();
    repeat (2) tick();
    check_val("rst_tag_ip", 32'(MUL_Tag_ip), 32'd0);
    check_val("rst_src", 32'({Source_Reg1, Source_Reg2}), 32'd0);
    check_val("rst_full", 32'(RS_Full), 32'd0);
    check_val("rst_occ", 32'(Occupancy), 32'd0);
    check_val("rst_disp_tag", 32'(Disp_Tag), 32'd5);
    reset = 1'b0;
    repeat (2) tick();

    // ready dispatch
    drive_disp(3'd0, 8'd5, 3'd0, 8'd2);
    check_val("t1_disp_tag", 32'(Disp_Tag), 32'd5);
    push_exp(3'd5, 8'd5, 8'd2);
    tick();
    clear_disp();
    check_val("t1_occ1", 32'(Occupancy), 32'd1);
    check_val("t1_no_issue_yet", 32'(MUL_Tag_ip), 32'd0);
    tick();
    check_val("t1_issue", 32'(MUL_Tag_ip), 32'd5);
    check_val("t1_occ0", 32'(Occupancy), 32'd0);
    tick();
    check_val("t1_pulse_end", 32'(MUL_Tag_ip), 32'd0);
    repeat (2) tick();

    // CDB wakeup
    drive_disp(3'd2, 8'hEE, 3'd0, 8'd15);
    check_val("t2_disp_tag", 32'(Disp_Tag), 32'd5);
    push_exp(3'd5, 8'd1, 8'd15);
    tick();
    clear_disp();
    repeat (2) tick();
    CDB_Valid = 1'b1;
    CDB_Tag   = 3'd2;
    CDB_Data  = 8'd1;
    tick();
    CDB_Valid = 1'b0;
    check_val("t2_wait", 32'(MUL_Tag_ip), 32'd0);
    tick();
    check_val("t2_issue", 32'(MUL_Tag_ip), 32'd5);
    check_val("t2_src1", 32'(Source_Reg1), 32'd1);
    repeat (3) tick();

    // same-cycle forward
    drive_disp(3'd3, 8'hEE, 3'd0, 8'd9);
    CDB_Valid = 1'b1;
    CDB_Tag   = 3'd3;
    CDB_Data  = 8'd7;
    push_exp(3'd5, 8'd7, 8'd9);
    tick();
    clear_disp();
    CDB_Valid = 1'b0;
    check_val("t3_occ", 32'(Occupancy), 32'd1);
    tick();
    check_val("t3_issue", 32'(MUL_Tag_ip), 32'd5);
    check_val("t3_src1", 32'(Source_Reg1), 32'd7);
    repeat (3) tick();

    // both operands woken by one broadcast
    drive_disp(3'd1, 8'h00, 3'd1, 8'h00);
    push_exp(3'd5, 8'h33, 8'h33);
    tick();
    clear_disp();
    CDB_Valid = 1'b1;
    CDB_Tag   = 3'd1;
    CDB_Data  = 8'h33;
    tick();
    CDB_Valid = 1'b0;
    tick();
    check_val("t3b_issue", 32'(MUL_Tag_ip), 32'd5);
    repeat (3) tick();

    // busy multiplier, full station, priority and issue spacing
    MUL_Status = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive_disp(3'd0, 8'(10 * (k + 1)), 3'd0, 8'(10 * (k + 1) + 1));
      check_val("t4_disp_tag", 32'(Disp_Tag), 32'(5 + k));
      push_exp(3'(5 + k), 8'(10 * (k + 1)), 8'(10 * (k + 1) + 1));
      tick();
    end
    drive_disp(3'd0, 8'd99, 3'd0, 8'd99);
    check_val("t4_full", 32'(RS_Full), 32'd1);
    check_val("t4_occ3", 32'(Occupancy), 32'd3);
    tick();
    clear_disp();
    check_val("t4_drop_occ", 32'(Occupancy), 32'd3);
    check_val("t4_busy_no_issue", 32'(MUL_Tag_ip), 32'd0);
    MUL_Status = 1'b0;
    tick();
    check_val("t4_first", 32'(MUL_Tag_ip), 32'd5);
    check_val("t4_occ2", 32'(Occupancy), 32'd3 - 32'd1);
    tick();
    check_val("t5_blocked", 32'(MUL_Tag_ip), 32'd0);
    check_val("t5_occ2", 32'(Occupancy), 32'd2);
    tick();
    check_val("t5_second", 32'(MUL_Tag_ip), 32'd6);
    tick();
    check_val("t5_blocked2", 32'(MUL_Tag_ip), 32'd0);
    tick();
    check_val("t5_third", 32'(MUL_Tag_ip), 32'd7);
    check_val("t5_occ0", 32'(Occupancy), 32'd0);
    repeat (3) tick();

    // dispatch and issue in the same cycle
    drive_disp(3'd0, 8'd1, 3'd0, 8'd2);
    push_exp(3'd5, 8'd1, 8'd2);
    tick();
    drive_disp(3'd0, 8'd3, 3'd0, 8'd4);
    check_val("t6_disp_tag", 32'(Disp_Tag), 32'd6);
    push_exp(3'd6, 8'd3, 8'd4);
    tick();
    clear_disp();
    check_val("t6_issue_a", 32'(MUL_Tag_ip), 32'd5);
    check_val("t6_occ", 32'(Occupancy), 32'd1);
    tick();
    check_val("t6_blocked", 32'(MUL_Tag_ip), 32'd0);
    tick();
    check_val("t6_issue_b", 32'(MUL_Tag_ip), 32'd6);
    repeat (3) tick();

    // asynchronous reset with entries and an issue in flight
    MUL_Status = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive_disp(3'd0, 8'(k + 1), 3'd0, 8'(k + 1));
      tick();
    end
    clear_disp();
    push_exp(3'd5, 8'd1, 8'd1);
    MUL_Status = 1'b0;
    tick();
    check_val("t7_inflight", 32'(MUL_Tag_ip), 32'd5);
    check_val("t7_occ2", 32'(Occupancy), 32'd2);
    #2;
    reset = 1'b1;
    #1;
    check_val("t7_async_tag", 32'(MUL_Tag_ip), 32'd0);
    check_val("t7_async_occ", 32'(Occupancy), 32'd0);
    check_val("t7_async_full", 32'(RS_Full), 32'd0);
    check_val("t7_async_disp_tag", 32'(Disp_Tag), 32'd5);
    repeat (2) tick();
    reset = 1'b0;
    repeat (3) tick();
    check_val("t7_post_occ", 32'(Occupancy), 32'd0);
    check_val("t7_post_tag", 32'(MUL_Tag_ip), 32'd0);
    check_val("sb_drain", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
